// File: rtl/rf_read_uart_tx_if.sv
// Request/serial bundle between the ALU read path and the RF UART transmitter.
// The master side raises read_data_en and presents data_i; the slave drives the line and status.
interface rf_read_uart_tx_if;
    logic       read_data_en;
    logic [7:0] data_i;
    logic       tx_o;
    logic       busy_o;
    logic       tx_done_o;
    logic       overrun_o;

    modport master (
        output read_data_en,
        output data_i,
        input  tx_o,
        input  busy_o,
        input  tx_done_o,
        input  overrun_o
    );

    modport slave (
        input  read_data_en,
        input  data_i,
        output tx_o,
        output busy_o,
        output tx_done_o,
        output overrun_o
    );
endinterface

// File: rtl/rf_read_uart_tx.sv
// RF read-port UART transmitter: one 8N1 frame per rising edge of read_data_en,
// with a one-byte holding buffer so back-to-back requests go out without a gap.
module rf_read_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input logic              clk,
    input logic              rst,
    rf_read_uart_tx_if.slave bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] BAUD_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       pending_data;
    logic             pending_valid;
    logic             prev_en;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;

    logic request;
    logic bit_end;
    logic stop_end;

    assign request  = bus.read_data_en & ~prev_en;
    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign stop_end = (state == STOP) && bit_end;

    assign bus.tx_o      = tx_q;
    assign bus.busy_o    = busy_q;
    assign bus.tx_done_o = done_q;
    assign bus.overrun_o = overrun_q;

    // prev_en resets high so an enable held through reset is not seen as a new request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            pending_data  <= '0;
            pending_valid <= 1'b0;
            prev_en       <= 1'b1;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            prev_en <= bus.read_data_en;
            done_q  <= 1'b0;

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    tx_q     <= 1'b1;
                    if (request) begin
                        state     <= START;
                        shift_reg <= bus.data_i;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        state     <= DATA;
                        tx_q      <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_q      <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end

                STOP: begin
                    // The done flop is set one cycle early so it lands on the last stop cycle.
                    if (baud_cnt == BAUD_PRE_LAST) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        if (pending_valid) begin
                            state         <= START;
                            shift_reg     <= pending_data;
                            pending_valid <= 1'b0;
                            tx_q          <= 1'b0;
                        end else if (request) begin
                            state     <= START;
                            shift_reg <= bus.data_i;
                            tx_q      <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase

            // A request at the end of STOP with an empty buffer is taken directly above.
            if (request && (state != IDLE)) begin
                if (pending_valid) begin
                    overrun_q <= 1'b1;
                end else if (!stop_end) begin
                    pending_data  <= bus.data_i;
                    pending_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_read_uart_tx.sv
// Testbench for rf_read_uart_tx: directed scenarios plus random traffic, every
// cycle compared against a frame-timeline model of the transmitter.
module tb_rf_read_uart_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic rst;
    rf_read_uart_tx_if bus_if ();

    rf_read_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int fail_count  = 0;
    int tick_no     = 0;
    int done_count  = 0;
    int last_done_tick = -1;

    // Reference model: a frame is just a position k within a 10-bit timeline.
    bit         m_active;
    int         m_k;
    logic [7:0] m_cur;
    logic [7:0] m_pend;
    bit         m_pend_valid;
    bit         m_overrun;
    bit         m_prev;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s at tick %0d: got %0h expected %0h", tag, tick_no, got, want);
        end
    endtask

    function automatic logic model_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    task automatic model_step(input logic r, input logic en, input logic [7:0] d);
        bit req;
        if (r) begin
            m_active = 0; m_k = 0; m_pend_valid = 0; m_overrun = 0; m_prev = 1;
            return;
        end
        req    = en && !m_prev;
        m_prev = en;
        if (m_active) begin
            if (m_k == FRAME - 1) begin
                if (m_pend_valid) begin
                    m_cur = m_pend; m_pend_valid = 0; m_k = 0;
                    if (req) m_overrun = 1;
                end else if (req) begin
                    m_cur = d; m_k = 0;
                end else begin
                    m_active = 0; m_k = 0;
                end
            end else begin
                m_k++;
                if (req) begin
                    if (m_pend_valid) m_overrun = 1;
                    else begin m_pend = d; m_pend_valid = 1; end
                end
            end
        end else if (req) begin
            m_active = 1; m_cur = d; m_k = 0;
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic en, input logic [7:0] d);
        rst = r;
        bus_if.read_data_en = en;
        bus_if.data_i = d;
        @(posedge clk);
        @(negedge clk);
        tick_no++;
        model_step(r, en, d);
        check_output("tx_o", 32'(bus_if.tx_o), 32'(model_tx()));
        check_output("busy_o", 32'(bus_if.busy_o), 32'(m_active || m_pend_valid));
        check_output("tx_done_o", 32'(bus_if.tx_done_o), 32'(m_active && (m_k == FRAME - 1)));
        check_output("overrun_o", 32'(bus_if.overrun_o), 32'(m_overrun));
        if (bus_if.tx_done_o === 1'b1) begin
            done_count++;
            last_done_tick = tick_no;
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int t0, d0, first_done;
        logic r, en;
        rst = 1'b1;
        bus_if.read_data_en = 1'b0;
        bus_if.data_i = 8'h00;
        m_prev = 1;

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 8'h00);
        idle_ticks(2);

        // Single 0xA5 frame
        apply_stimulus(1'b0, 1'b1, 8'hA5);
        t0 = tick_no; d0 = done_count;
        idle_ticks(45);
        check_output("a5_done_count", 32'(done_count - d0), 32'd1);
        check_output("a5_done_tick", 32'(last_done_tick - t0), 32'd39);

        // Enable held high for 100 cycles
        d0 = done_count;
        for (int i = 0; i < 100; i++) apply_stimulus(1'b0, 1'b1, 8'h3C);
        idle_ticks(5);
        check_output("held_done_count", 32'(done_count - d0), 32'd1);

        // Two requests, second at cycle 10
        d0 = done_count;
        apply_stimulus(1'b0, 1'b1, 8'h11);
        t0 = tick_no;
        idle_ticks(9);
        apply_stimulus(1'b0, 1'b1, 8'h22);
        idle_ticks(40);
        first_done = last_done_tick;
        idle_ticks(35);
        check_output("pair_done_count", 32'(done_count - d0), 32'd2);
        check_output("pair_second_done", 32'(last_done_tick - t0), 32'd79);
        check_output("pair_gap", 32'(last_done_tick - first_done), 32'd40);
        check_output("pair_overrun", 32'(bus_if.overrun_o), 32'd0);

        // Three requests in one frame: third is dropped
        d0 = done_count;
        apply_stimulus(1'b0, 1'b1, 8'h11);
        idle_ticks(4);
        apply_stimulus(1'b0, 1'b1, 8'h22);
        idle_ticks(6);
        apply_stimulus(1'b0, 1'b1, 8'h33);
        idle_ticks(90);
        check_output("triple_done_count", 32'(done_count - d0), 32'd2);
        check_output("triple_overrun", 32'(bus_if.overrun_o), 32'd1);
        apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("overrun_cleared", 32'(bus_if.overrun_o), 32'd0);

        // Reset at cycle 15 of a frame, then a fresh frame
        idle_ticks(2);
        apply_stimulus(1'b0, 1'b1, 8'hC3);
        idle_ticks(14);
        d0 = done_count;
        apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("abort_tx", 32'(bus_if.tx_o), 32'd1);
        check_output("abort_busy", 32'(bus_if.busy_o), 32'd0);
        idle_ticks(45);
        check_output("abort_no_done", 32'(done_count - d0), 32'd0);
        apply_stimulus(1'b0, 1'b1, 8'h96);
        idle_ticks(45);
        check_output("after_abort_done", 32'(done_count - d0), 32'd1);

        // Request coincident with the end of STOP
        apply_stimulus(1'b0, 1'b1, 8'h81);
        idle_ticks(39);
        apply_stimulus(1'b0, 1'b1, 8'h5A);
        check_output("coincident_start", 32'(bus_if.tx_o), 32'd0);
        check_output("coincident_overrun", 32'(bus_if.overrun_o), 32'd0);
        idle_ticks(45);

        // Enable held high through reset starts nothing
        apply_stimulus(1'b1, 1'b1, 8'hFF);
        apply_stimulus(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 8'hFF);
        check_output("held_through_reset_busy", 32'(bus_if.busy_o), 32'd0);
        idle_ticks(3);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            r  = ($urandom_range(0, 399) == 0);
            en = ($urandom_range(0, 9) < 3);
            apply_stimulus(r, en, 8'($urandom));
        end
        idle_ticks(100);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end
endmodule

// File: doc/rf_read_uart_tx.md
RF_READ_UART_TX -- requirements
Module: rf_read_uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: read_data_en  input  1  ALU read-request level; high while an RD_rf instruction is presented.
REQ-005 SHALL have port: data_i  input  8  byte to send, valid in the cycle read_data_en rises.
REQ-006 SHALL have port: tx_o  output  1  UART serial line, idle high.
REQ-007 SHALL have port: busy_o  output  1  high while a frame is on the line or a byte is pending.
REQ-008 SHALL have port: tx_done_o  output  1  one-cycle pulse at the end of each stop bit.
REQ-009 SHALL have port: overrun_o  output  1  sticky; a request was dropped.

Function
REQ-010 SHALL register read_data_en into prev_en each cycle; a request SHALL be read_data_en=1 AND prev_en=0.
REQ-011 SHALL send exactly one frame per request, regardless of how long read_data_en stays high.
REQ-012 SHALL use frame format 8N1: start bit 0, data bits LSB first, stop bit 1, each CLKS_PER_BIT cycles, 10*CLKS_PER_BIT cycles per frame.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 SHALL move IDLE->START on a request: data_i is latched into the shift register and tx_o=0 from the next cycle (1-cycle latency).
REQ-015 SHALL move START->DATA after CLKS_PER_BIT cycles.
REQ-016 SHALL hold each DATA bit CLKS_PER_BIT cycles with a bit index of 0..7, and move DATA->STOP after bit 7.
REQ-017 SHALL, at the end of STOP, pulse tx_done_o for exactly 1 cycle (the last STOP cycle).
REQ-018 SHALL, at the end of STOP, go to START loading the pending byte if pending_valid=1, with no idle cycle between frames; otherwise it SHALL go to IDLE.
REQ-019 SHALL use a baud counter of width $clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is held at 0 in IDLE.
REQ-020 SHALL provide a one-entry pending buffer: a request while not IDLE with pending empty captures data_i and sets pending_valid=1.
REQ-021 SHALL, on a request while not IDLE with pending full, drop the request, keep the existing pending byte unchanged, and set overrun_o=1 until rst.
REQ-022 SHALL treat a request in the same cycle as end of STOP as follows: with pending empty, it goes directly to START with data_i; with pending full, it is dropped and sets overrun_o.
REQ-023 SHALL drive busy_o = (state != IDLE) OR pending_valid, registered.
REQ-024 SHALL drive tx_o high in IDLE and in STOP.
REQ-025 SHALL keep tx_o glitch-free by driving it from a flop.

Reset
REQ-026 SHALL, on rst, set state=IDLE, tx_o=1, busy_o=0, tx_done_o=0, overrun_o=0, pending_valid=0, baud counter=0, bit index=0.
REQ-027 SHALL reset prev_en to 1, so a read_data_en held high through reset starts no frame.
REQ-028 SHALL, on rst during a frame, abort the frame with tx_o=1 in the next cycle, emit no tx_done_o pulse, and discard the pending byte.

Verification (CLKS_PER_BIT=4)
REQ-029 SHALL cover: a single 1-cycle request with data_i=0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting 1 cycle after the request; tx_done_o high for 1 cycle at cycle 40; busy_o low afterwards.
REQ-030 SHALL cover: read_data_en held high for 100 cycles with data 0x3C -> exactly one frame and one tx_done_o pulse.
REQ-031 SHALL cover: requests 0x11 then 0x22 (second at cycle 10) -> two contiguous frames totalling 80 cycles with no idle gap, two tx_done_o pulses, and overrun_o=0.
REQ-032 SHALL cover: requests 0x11, 0x22, 0x33 within the first frame -> 0x11 and 0x22 transmitted, 0x33 dropped, overrun_o=1 until rst.
REQ-033 SHALL cover: rst asserted at cycle 15 of a frame -> tx_o=1 and busy_o=0 next cycle, no tx_done_o, and a fresh request afterwards produces a correct frame.
REQ-034 SHALL cover: a request with 0x5A in the same cycle as the first frame's end of STOP -> the 0x5A start bit in the next cycle and overrun_o=0.
